// File: rtl/seq_alu.sv
// seq_alu: registered ALU with a valid/ready request side and a one-cycle
// result pulse. Single-cycle ops finish in one cycle. When SEQ_ALU_MULDIV_EN
// is defined, an iterative unsigned multiply/divide unit is also built; it
// takes WIDTH+1 cycles per op. Without the macro, MULTU/DIVU are illegal ops.
`timescale 1ns/1ps
module seq_alu #(
   parameter  int WIDTH = 32,
   localparam int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic [SHW-1:0]   shamt,
   input  logic             clr_flags,
   output logic             out_valid,
   output logic [WIDTH-1:0] result_lo,
   output logic [WIDTH-1:0] result_hi,
   output logic [3:0]       flags
);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_AND  = 4'd2, OP_OR   = 4'd3,
      OP_LESS = 4'd4,  OP_PASS = 4'd5,  OP_SLL  = 4'd6, OP_SRL  = 4'd7,
      OP_SRA  = 4'd8,  OP_MULTU = 4'd9, OP_DIVU = 4'd10
   } op_e;

   state_e           state, state_nx;
   logic             accept;
   logic [WIDTH-1:0] add_res, sub_res;
   logic [WIDTH-1:0] alu_lo, alu_hi;
   logic             set_ovf, set_div0, set_ill;
   logic             start_mul, start_div;
   logic [2:0]       sticky_nx;

   assign accept  = in_valid && in_ready;
   assign add_res = x + y;
   assign sub_res = x - y;

   // Decode the request and compute every single-cycle result.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so
      // that no path leaves it unassigned and infers a latch.
      alu_lo    = '0;
      alu_hi    = '0;
      set_ovf   = 1'b0;
      set_div0  = 1'b0;
      set_ill   = 1'b0;
      start_mul = 1'b0;
      start_div = 1'b0;
      case (op_e'(op))
         OP_ADD: begin
            alu_lo  = add_res;
            set_ovf = (x[WIDTH-1] == y[WIDTH-1]) && (add_res[WIDTH-1] != x[WIDTH-1]);
         end
         OP_SUB: begin
            alu_lo  = sub_res;
            set_ovf = (x[WIDTH-1] != y[WIDTH-1]) && (sub_res[WIDTH-1] != x[WIDTH-1]);
         end
         OP_AND:  alu_lo = x & y;
         OP_OR:   alu_lo = x | y;
         OP_LESS: alu_lo = {{(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
         OP_PASS: alu_lo = y;
         OP_SLL:  alu_lo = x << shamt;
         OP_SRL:  alu_lo = x >> shamt;
         OP_SRA:  alu_lo = $signed(x) >>> shamt;
`ifdef SEQ_ALU_MULDIV_EN
         OP_MULTU: start_mul = 1'b1;
         OP_DIVU: begin
            // Divide by zero finishes immediately with a defined result.
            if (y == '0) begin
               alu_lo   = '1;
               alu_hi   = x;
               set_div0 = 1'b1;
            end else begin
               start_div = 1'b1;
            end
         end
`endif
         default: set_ill = 1'b1;
      endcase
   end

   // Sticky flags: a clear drops the old bits, a completion setting a bit wins.
   assign sticky_nx = (clr_flags ? 3'b000 : flags[3:1])
                    | ({set_ill, set_div0, set_ovf} & {3{accept}});

`ifdef SEQ_ALU_MULDIV_EN
   // Iterative unit: work_hi/work_lo form the 2*WIDTH accumulator for
   // multiply, and the remainder/quotient pair for restoring division.
   logic [WIDTH-1:0] work_hi, work_lo, opnd;
   logic [SHW-1:0]   cnt;
   logic [WIDTH:0]   mul_sum, div_shift, div_diff;
   logic [WIDTH-1:0] step_hi, step_lo;
   logic             busy, last_step;

   assign busy      = (state == S_MUL) || (state == S_DIV);
   assign last_step = (cnt == SHW'(WIDTH-1));

   // One shift-add or one restoring-subtract step per cycle.
   always_comb begin
      mul_sum   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, opnd} : '0);
      div_shift = {work_hi, work_lo[WIDTH-1]};
      div_diff  = div_shift - {1'b0, opnd};
      step_hi   = work_hi;
      step_lo   = work_lo;
      if (state == S_MUL) begin
         step_hi = mul_sum[WIDTH:1];
         step_lo = {mul_sum[0], work_lo[WIDTH-1:1]};
      end else if (div_diff[WIDTH]) begin
         step_hi = div_shift[WIDTH-1:0];
         step_lo = {work_lo[WIDTH-2:0], 1'b0};
      end else begin
         step_hi = div_diff[WIDTH-1:0];
         step_lo = {work_lo[WIDTH-2:0], 1'b1};
      end
   end

   // Latch operands at accept, then iterate while busy.
   always_ff @(posedge clk) begin
      if (rst) begin
         work_hi <= '0;
         work_lo <= '0;
         opnd    <= '0;
         cnt     <= '0;
      end else if (accept && (start_mul || start_div)) begin
         work_hi <= '0;
         work_lo <= start_mul ? y : x;
         opnd    <= start_mul ? x : y;
         cnt     <= '0;
      end else if (busy) begin
         work_hi <= step_hi;
         work_lo <= step_lo;
         cnt     <= cnt + SHW'(1);
      end
   end
`endif

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: registers are written with non-blocking assignments so every
      // flop samples pre-edge values regardless of block ordering.
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   // Next-state logic and handshake outputs.
   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               if (start_mul)      state_nx = S_MUL;
               else if (start_div) state_nx = S_DIV;
               else                state_nx = S_DONE;
            end
         end
`ifdef SEQ_ALU_MULDIV_EN
         S_MUL, S_DIV: if (last_step) state_nx = S_DONE;
`endif
         S_DONE: begin
            out_valid = 1'b1;
            state_nx  = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Result and flag registers; they hold until the next completion.
   always_ff @(posedge clk) begin
      if (rst) begin
         result_lo <= '0;
         result_hi <= '0;
         flags     <= 4'b0000;
      end else begin
         flags[3:1] <= sticky_nx;
         if (accept && !start_mul && !start_div) begin
            result_lo <= alu_lo;
            result_hi <= alu_hi;
            flags[0]  <= ({alu_hi, alu_lo} == '0);
         end
`ifdef SEQ_ALU_MULDIV_EN
         else if (busy && last_step) begin
            result_lo <= step_lo;
            result_hi <= step_hi;
            flags[0]  <= ({step_hi, step_lo} == '0);
         end
`endif
      end
   end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=32): directed vector table, a few
// multi-cycle corner sequences, then random ops against a reference model.
// Expectations follow SEQ_ALU_MULDIV_EN the same way the design does.
`timescale 1ns/1ps
module tb_seq_alu;

   localparam int W = 32;
`ifdef SEQ_ALU_MULDIV_EN
   localparam bit MD = 1'b1;
`else
   localparam bit MD = 1'b0;
`endif
   localparam int MLAT = MD ? W + 1 : 1;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [3:0]   op;
   logic [W-1:0] x, y;
   logic [4:0]   shamt;
   logic         clr_flags;
   logic         out_valid;
   logic [W-1:0] result_lo, result_hi;
   logic [3:0]   flags;

   int n_vec = 0;
   int n_err = 0;
   logic [2:0] m_sticky;

   seq_alu #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .x(x), .y(y), .shamt(shamt), .clr_flags(clr_flags),
      .out_valid(out_valid), .result_lo(result_lo), .result_hi(result_hi),
      .flags(flags)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]   op;
      logic [W-1:0] x, y;
      logic [4:0]   sh;
      logic         clr;
      logic [W-1:0] lo, hi;
      logic [3:0]   fl;
      int           lat;
   } vec_t;

   vec_t vt[$];

   function automatic vec_t mk(input logic [3:0] o, input logic [W-1:0] a, b,
                               input logic [4:0] s, input logic c,
                               input logic [W-1:0] lo, hi,
                               input logic [3:0] fl, input int lat);
      vec_t v;
      v.op = o; v.x = a; v.y = b; v.sh = s; v.clr = c;
      v.lo = lo; v.hi = hi; v.fl = fl; v.lat = lat;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: results straight from the arithmetic definitions.
   function automatic void model(input logic [3:0] o, input logic [W-1:0] a, b,
                                 input logic [4:0] s,
                                 output logic [W-1:0] lo, hi,
                                 output logic [2:0] set, output int lat);
      longint sv;
      logic [63:0] prod;
      lo = '0; hi = '0; set = 3'b000; lat = 1;
      case (o)
         4'd0: begin
            lo = a + b;
            sv = longint'($signed(a)) + longint'($signed(b));
            set[0] = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
         end
         4'd1: begin
            lo = a - b;
            sv = longint'($signed(a)) - longint'($signed(b));
            set[0] = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
         end
         4'd2: lo = a & b;
         4'd3: lo = a | b;
         4'd4: lo = ($signed(a) < $signed(b)) ? 1 : 0;
         4'd5: lo = b;
         4'd6: lo = a << s;
         4'd7: lo = a >> s;
         4'd8: lo = $signed(a) >>> s;
         4'd9: begin
            if (MD) begin
               prod = 64'(a) * 64'(b);
               lo = prod[31:0]; hi = prod[63:32]; lat = W + 1;
            end else set[2] = 1'b1;
         end
         4'd10: begin
            if (!MD) set[2] = 1'b1;
            else if (b == 0) begin lo = '1; hi = a; set[1] = 1'b1; end
            else begin lo = a / b; hi = a % b; lat = W + 1; end
         end
         default: set[2] = 1'b1;
      endcase
   endfunction

   // Issue one op, wait (bounded) for the pulse, compare everything.
   task automatic run_op(input string name, input logic [3:0] o,
                         input logic [W-1:0] a, b, input logic [4:0] s,
                         input logic c, input logic [W-1:0] e_lo, e_hi,
                         input logic [3:0] e_fl, input int e_lat);
      int lat;
      int ready_seen;
      @(negedge clk);
      check({name, ".ready"}, 64'(in_ready), 64'd1);
      in_valid = 1'b1; op = o; x = a; y = b; shamt = s; clr_flags = c;
      @(posedge clk);
      #1;
      in_valid = 1'b0; clr_flags = 1'b0;
      x = $urandom; y = $urandom;
      lat = 0; ready_seen = 0;
      while (1) begin
         @(negedge clk);
         lat++;
         if (in_ready) ready_seen++;
         if (out_valid) break;
         if (lat > 200) begin
            check({name, ".timeout"}, 64'(lat), 64'(e_lat));
            return;
         end
      end
      check({name, ".lat"},   64'(lat), 64'(e_lat));
      check({name, ".lo"},    64'(result_lo), 64'(e_lo));
      check({name, ".hi"},    64'(result_hi), 64'(e_hi));
      check({name, ".flags"}, 64'(flags), 64'(e_fl));
      if (e_lat > 1) check({name, ".busy"}, 64'(ready_seen), 64'd0);
   endtask

   initial begin
      logic [W-1:0] e_lo, e_hi;
      logic [2:0]   e_set;
      logic [3:0]   ro;
      logic [W-1:0] ra, rb;
      logic [4:0]   rs;
      logic         rc;
      int           e_lat, n_out, n_busy;

      rst = 1'b1; in_valid = 1'b0; op = '0; x = '0; y = '0; shamt = '0;
      clr_flags = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("rst.ready", 64'(in_ready), 64'd1);
      check("rst.valid", 64'(out_valid), 64'd0);
      check("rst.lo",    64'(result_lo), 64'd0);
      check("rst.hi",    64'(result_hi), 64'd0);
      check("rst.flags", 64'(flags), 64'd0);

      // Directed table: expected flags include sticky history from earlier rows.
      vt.push_back(mk(4'd0,  32'h7FFFFFFF, 32'd1, 5'd0, 0, 32'h80000000, 0, 4'b0010, 1));
      vt.push_back(mk(4'd2,  32'd0, 32'd5, 5'd0, 0, 32'd0, 0, 4'b0011, 1));
      vt.push_back(mk(4'd1,  32'd5, 32'd5, 5'd0, 0, 32'd0, 0, 4'b0011, 1));
      vt.push_back(mk(4'd4,  32'hFFFFFFFF, 32'd1, 5'd0, 0, 32'd1, 0, 4'b0010, 1));
      vt.push_back(mk(4'd8,  32'h80000000, 32'd0, 5'd4, 0, 32'hF8000000, 0, 4'b0010, 1));
      vt.push_back(mk(4'd6,  32'd1, 32'd0, 5'd31, 0, 32'h80000000, 0, 4'b0010, 1));
      vt.push_back(mk(4'd7,  32'h80000000, 32'd0, 5'd31, 0, 32'd1, 0, 4'b0010, 1));
      vt.push_back(mk(4'd3,  32'h0F0, 32'hF00, 5'd0, 0, 32'hFF0, 0, 4'b0010, 1));
      vt.push_back(mk(4'd5,  32'd123, 32'd0, 5'd0, 0, 32'd0, 0, 4'b0011, 1));
      vt.push_back(mk(4'd1,  32'h80000000, 32'd1, 5'd0, 0, 32'h7FFFFFFF, 0, 4'b0010, 1));
      vt.push_back(mk(4'd12, 32'd5, 32'd6, 5'd0, 0, 32'd0, 0, 4'b1011, 1));
      vt.push_back(mk(4'd0,  32'd1, 32'd1, 5'd0, 1, 32'd2, 0, 4'b0000, 1));
      vt.push_back(mk(4'd0,  32'h7FFFFFFF, 32'd1, 5'd0, 1, 32'h80000000, 0, 4'b0010, 1));
      vt.push_back(mk(4'd9,  32'hFFFFFFFF, 32'd2, 5'd0, 0, MD ? 32'hFFFFFFFE : 0,
                      MD ? 32'd1 : 0, MD ? 4'b0010 : 4'b1011, MLAT));
      vt.push_back(mk(4'd10, 32'd100, 32'd7, 5'd0, 0, MD ? 32'd14 : 0,
                      MD ? 32'd2 : 0, MD ? 4'b0010 : 4'b1011, MLAT));
      vt.push_back(mk(4'd10, 32'd9, 32'd0, 5'd0, 0, MD ? 32'hFFFFFFFF : 0,
                      MD ? 32'd9 : 0, MD ? 4'b0110 : 4'b1011, 1));
      vt.push_back(mk(4'd9,  32'd0, 32'd123, 5'd0, 0, 0, 0, MD ? 4'b0111 : 4'b1011, MLAT));
      vt.push_back(mk(4'd10, 32'd5, 32'd7, 5'd0, 0, 0, MD ? 32'd5 : 0,
                      MD ? 4'b0110 : 4'b1011, MLAT));
      vt.push_back(mk(4'd15, 32'd1, 32'd2, 5'd0, 1, 0, 0, 4'b1001, 1));
      vt.push_back(mk(4'd6,  32'd3, 32'd0, 5'd0, 0, 32'd3, 0, 4'b1000, 1));

      foreach (vt[i])
         run_op($sformatf("vec%0d", i), vt[i].op, vt[i].x, vt[i].y, vt[i].sh,
                vt[i].clr, vt[i].lo, vt[i].hi, vt[i].fl, vt[i].lat);

      // Standalone clear pulse drops the sticky bits, keeps ZERO.
      @(negedge clk);
      clr_flags = 1'b1;
      @(negedge clk);
      clr_flags = 1'b0;
      check("clr.flags", 64'(flags), 64'd0);
      m_sticky = 3'b000;

      // MULTU with request pulses while busy: exactly one result pulse.
      @(negedge clk);
      check("busy.ready", 64'(in_ready), 64'd1);
      in_valid = 1'b1; op = 4'd9; x = 32'd7; y = 32'd6;
      @(posedge clk);
      #1;
      in_valid = 1'b0; op = 4'd0; x = 32'd1; y = 32'd1;
      n_out = 0; n_busy = 0;
      for (int i = 0; i < 45; i++) begin
         @(negedge clk);
         if (out_valid) n_out++;
         if (!in_ready) n_busy++;
         in_valid = !in_ready && (i % 2 == 0);
      end
      in_valid = 1'b0;
      model(4'd9, 32'd7, 32'd6, 5'd0, e_lo, e_hi, e_set, e_lat);
      m_sticky = m_sticky | e_set;
      check("busy.pulses", 64'(n_out), 64'd1);
      check("busy.cycles", 64'(n_busy), 64'(MLAT));
      check("busy.lo",     64'(result_lo), 64'(e_lo));
      check("busy.flags",  64'(flags), 64'({m_sticky, ({e_hi, e_lo} == 0)}));

      // Reset ten cycles into a MULTU aborts it silently.
      @(negedge clk);
      in_valid = 1'b1; op = 4'd9; x = 32'h1234; y = 32'h5678;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort.ready", 64'(in_ready), 64'd1);
      check("abort.valid", 64'(out_valid), 64'd0);
      check("abort.lo",    64'(result_lo), 64'd0);
      check("abort.hi",    64'(result_hi), 64'd0);
      check("abort.flags", 64'(flags), 64'd0);
      n_out = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (out_valid) n_out++;
      end
      check("abort.pulses", 64'(n_out), 64'd0);
      m_sticky = 3'b000;

      // Random ops against the reference model.
      for (int i = 0; i < 40; i++) begin
         ro = 4'($urandom_range(0, 15));
         ra = $urandom;
         rb = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom);
         if ($urandom_range(0, 2) == 0) rb = 32'($urandom_range(1, 50));
         rs = 5'($urandom_range(0, 31));
         rc = ($urandom_range(0, 7) == 0);
         model(ro, ra, rb, rs, e_lo, e_hi, e_set, e_lat);
         m_sticky = (rc ? 3'b000 : m_sticky) | e_set;
         run_op($sformatf("rnd%0d_op%0d", i, ro), ro, ra, rb, rs, rc,
                e_lo, e_hi, {m_sticky, ({e_hi, e_lo} == 0)}, e_lat);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
